tspi_response_receiver: RTL

//  Front end of the SD-over-SPI response path. Deserialises MISO (MSB first) on SCK-rise strobes and skips
//  0xFF idle bytes (Ncr / token wait). Forwards response bytes (R1, R3/R7, or data block after the 0xFE token)
//  as a valid/ready byte stream to the response checker. Detects timeout and output overflow.

---
 rtl/tspi_response_receiver_pkg.sv | 34 +++
 rtl/tspi_response_receiver_if.sv | 30 +++
 rtl/tspi_byte_shifter.sv | 48 ++++
 rtl/tspi_response_receiver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tspi_response_receiver_pkg.sv
// Shared types and constants for the SD-over-SPI response receive path.
// Response modes, FSM states, token values and default limits live here.
package tspi_response_receiver_pkg;

    typedef enum logic [1:0] {
        MODE_R1   = 2'd0,
        MODE_R37  = 2'd1,
        MODE_DATA = 2'd2
    } resp_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RESP,
        ST_WAIT_TOKEN,
        ST_RECEIVE,
        ST_DRAIN,
        ST_FINISH
    } rx_state_t;

    localparam logic [7:0] DATA_TOKEN    = 8'hFE;
    localparam logic [7:0] IDLE_BYTE     = 8'hFF;

    localparam int         NCR_MAX       = 8;
    localparam int         TOKEN_TIMEOUT = 65535;
    localparam int         DATA_BYTES    = 514;
    localparam int         R1_LEN        = 1;
    localparam int         R37_LEN       = 5;

    // Length of an R-type response including its first byte.
    function automatic int resp_len(resp_mode_t mode);
        return (mode == MODE_R37) ? R37_LEN : R1_LEN;
    endfunction

endpackage

// File: rtl/tspi_response_receiver_if.sv
// Control, serial input and byte-stream output bundle of the response receiver.
// master = controller/consumer side, slave = receiver.
interface tspi_response_receiver_if;
    import tspi_response_receiver_pkg::*;

    logic       start_i;
    resp_mode_t mode_i;
    logic       abort_i;
    logic       sample_i;
    logic       miso_i;
    logic       busy_o;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i;
    logic       byte_last_o;
    logic       timeout_o;
    logic       overflow_o;
    logic       done_o;

    modport master (
        output start_i, mode_i, abort_i, sample_i, miso_i, byte_ready_i,
        input  busy_o, byte_o, byte_valid_o, byte_last_o, timeout_o, overflow_o, done_o
    );

    modport slave (
        input  start_i, mode_i, abort_i, sample_i, miso_i, byte_ready_i,
        output busy_o, byte_o, byte_valid_o, byte_last_o, timeout_o, overflow_o, done_o
    );

endinterface

// File: rtl/tspi_byte_shifter.sv
// MSB-first deserialiser: 8-bit shift register and bit counter, byte_done on the 8th strobe.
// Zero latency: byte_done_o/byte_o are valid combinationally in the cycle of the 8th sample.
module tspi_byte_shifter
    import tspi_response_receiver_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       sample_i,
    input  logic       miso_i,
    output logic       byte_done_o,
    output logic [7:0] byte_o
);

    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       take;

    assign take = en_i && sample_i && !clear_i;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (clear_i) begin
            shift_d   = IDLE_BYTE;
            bit_cnt_d = '0;
        end else if (take) begin
            shift_d   = {shift_q[6:0], miso_i};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q   <= IDLE_BYTE;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The completed byte includes the bit arriving in this very cycle.
    assign byte_o      = {shift_q[6:0], miso_i};
    assign byte_done_o = take && (bit_cnt_q == 3'd7);

endmodule

// File: rtl/tspi_response_receiver.sv
// SD-over-SPI response receiver: skips 0xFF idle bytes, forwards R1/R3/R7 or data-block bytes.
// Byte valid one cycle after its last sample; 1-entry output register drops bytes (sticky overflow) when stalled.
module tspi_response_receiver
    import tspi_response_receiver_pkg::*;
#(
    parameter int NcrMax       = NCR_MAX,
    parameter int TokenTimeout = TOKEN_TIMEOUT,
    parameter int DataBytes    = DATA_BYTES
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    tspi_response_receiver_if.slave bus
);

    localparam int IdleW = $clog2(TokenTimeout + 1);
    localparam int RemW  = $clog2(DataBytes + 1);

    rx_state_t        state_q, state_d;
    resp_mode_t       mode_q, mode_d;
    logic [IdleW-1:0] idle_q, idle_d, idle_inc, idle_lim;
    logic [RemW-1:0]  rem_q, rem_d;
    logic             vld_q, vld_d;
    logic [7:0]       dat_q, dat_d;
    logic             last_q, last_d;
    logic             ovf_q, ovf_d;
    logic             timeout_q, timeout_d;

    logic             busy, start_acc, hs, clear;
    logic             push, push_last;
    logic             byte_done;
    logic [7:0]       shift_dat;

    assign busy      = (state_q == ST_WAIT_RESP) || (state_q == ST_WAIT_TOKEN) ||
                       (state_q == ST_RECEIVE)   || (state_q == ST_DRAIN);
    assign start_acc = (state_q == ST_IDLE) && bus.start_i && !bus.abort_i;
    assign hs        = vld_q && bus.byte_ready_i;
    assign idle_inc  = idle_q + IdleW'(1);
    assign idle_lim  = (state_q == ST_WAIT_TOKEN) ? IdleW'(TokenTimeout) : IdleW'(NcrMax);

    tspi_byte_shifter u_shifter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear),
        .en_i        (busy),
        .sample_i    (bus.sample_i),
        .miso_i      (bus.miso_i),
        .byte_done_o (byte_done),
        .byte_o      (shift_dat)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idle_d    = idle_q;
        rem_d     = rem_q;
        timeout_d = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    clear   = 1'b1;
                    mode_d  = bus.mode_i;
                    idle_d  = '0;
                    rem_d   = '0;
                    state_d = (bus.mode_i == MODE_DATA) ? ST_WAIT_TOKEN : ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP, ST_WAIT_TOKEN: begin
                if (byte_done) begin
                    if (shift_dat == IDLE_BYTE) begin
                        idle_d = idle_inc;
                        if (idle_inc == idle_lim) begin
                            timeout_d = 1'b1;
                            state_d   = ST_FINISH;
                        end
                    end else if (state_q == ST_WAIT_TOKEN) begin
                        if (shift_dat == DATA_TOKEN) begin
                            rem_d   = RemW'(DataBytes);
                            state_d = ST_RECEIVE;
                        end else begin
                            // Error token ends the data transfer on its own.
                            push      = 1'b1;
                            push_last = 1'b1;
                            state_d   = ST_DRAIN;
                        end
                    end else begin
                        push      = 1'b1;
                        push_last = (resp_len(mode_q) == 1);
                        rem_d     = RemW'(resp_len(mode_q) - 1);
                        state_d   = push_last ? ST_DRAIN : ST_RECEIVE;
                    end
                end
            end
            ST_RECEIVE: begin
                if (byte_done) begin
                    push      = 1'b1;
                    push_last = (rem_q == RemW'(1));
                    rem_d     = rem_q - RemW'(1);
                    if (push_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            // The held byte is the last one still owed, even if the true last byte was dropped.
            ST_DRAIN: begin
                if (hs) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (bus.abort_i) begin
            state_d   = ST_IDLE;
            clear     = 1'b1;
            push      = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        last_d = last_q;
        ovf_d  = ovf_q;
        if (hs) begin
            vld_d = 1'b0;
        end
        if (push) begin
            if (!vld_q || hs) begin
                vld_d  = 1'b1;
                dat_d  = shift_dat;
                last_d = push_last;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (start_acc) begin
            ovf_d = 1'b0;
        end
        if (bus.abort_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_R1;
            idle_q    <= '0;
            rem_q     <= '0;
            vld_q     <= 1'b0;
            dat_q     <= '0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idle_q    <= idle_d;
            rem_q     <= rem_d;
            vld_q     <= vld_d;
            dat_q     <= dat_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.busy_o       = busy;
    assign bus.byte_o       = dat_q;
    assign bus.byte_valid_o = vld_q;
    assign bus.byte_last_o  = last_q;
    assign bus.timeout_o    = timeout_q;
    assign bus.overflow_o   = ovf_q;
    assign bus.done_o       = (state_q == ST_FINISH);

endmodule
